// File: rtl/ripple_carry_adder_reg_if.sv
// Operand/result bundle for ripple_carry_adder_reg.
// The overflow signal exists only when RCA_OVERFLOW_EN is defined.
interface ripple_carry_adder_reg_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 in_valid;
    logic [BIT_WIDTH-1:0] in0;
    logic [BIT_WIDTH-1:0] in1;
    logic                 carry_in;
    logic [BIT_WIDTH-1:0] out;
    logic                 carry_out;
    logic                 out_valid;
`ifdef RCA_OVERFLOW_EN
    logic                 overflow;

    modport master (
        output in_valid, in0, in1, carry_in,
        input  out, carry_out, out_valid, overflow
    );

    modport slave (
        input  in_valid, in0, in1, carry_in,
        output out, carry_out, out_valid, overflow
    );
`else
    modport master (
        output in_valid, in0, in1, carry_in,
        input  out, carry_out, out_valid
    );

    modport slave (
        input  in_valid, in0, in1, carry_in,
        output out, carry_out, out_valid
    );
`endif
endinterface

// File: rtl/ripple_carry_adder_reg.sv
// Registered ripple-carry adder: {carry_out, out} = in0 + in1 + carry_in,
// one cycle of latency, valid flag carried alongside the sum.
// Optional feature macro: RCA_OVERFLOW_EN adds a registered two's-complement
// overflow flag (carry into MSB xor carry out of MSB).
// BIT_WIDTH must be at least 1.
module ripple_carry_adder_reg #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ripple_carry_adder_reg_if.slave        bus
);

    logic [BIT_WIDTH-1:0] sum_w;
    logic                 carry_w;

    logic [BIT_WIDTH-1:0] sum_d,   sum_q;
    logic                 carry_d, carry_q;
    logic                 valid_d, valid_q;

    // Full-adder chain; each stage keeps its own carry nets so the chain is
    // built from distinct signals rather than one self-referencing vector.
    for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_fa
        logic a_bit;
        logic b_bit;
        logic c_in;
        logic c_out;

        assign a_bit = bus.in0[i];
        assign b_bit = bus.in1[i];

        if (i == 0) begin : g_lsb
            assign c_in = bus.carry_in;
        end else begin : g_chain
            assign c_in = g_fa[i-1].c_out;
        end

        assign sum_w[i] = a_bit ^ b_bit ^ c_in;
        assign c_out    = (a_bit & b_bit) | (c_in & (a_bit ^ b_bit));
    end

    assign carry_w = g_fa[BIT_WIDTH-1].c_out;

`ifdef RCA_OVERFLOW_EN
    logic ovf_w;
    logic ovf_d, ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf_w = g_fa[BIT_WIDTH-1].c_out ^ g_fa[BIT_WIDTH-1].c_in;
`endif

    // Next-state: load the new sum only on valid samples, otherwise hold.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = bus.in_valid;
`ifdef RCA_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        if (bus.in_valid) begin
            sum_d   = sum_w;
            carry_d = carry_w;
`ifdef RCA_OVERFLOW_EN
            ovf_d   = ovf_w;
`endif
        end
    end

    // Output register stage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
`ifdef RCA_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
`ifdef RCA_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.out       = sum_q;
    assign bus.carry_out = carry_q;
    assign bus.out_valid = valid_q;
`ifdef RCA_OVERFLOW_EN
    assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_carry_adder_reg.sv
// Directed and random bench for ripple_carry_adder_reg at widths 32, 8 and 1.
module tb_ripple_carry_adder_reg;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ripple_carry_adder_reg_if #(.BIT_WIDTH(32)) if32 ();
    ripple_carry_adder_reg_if #(.BIT_WIDTH(8))  if8  ();
    ripple_carry_adder_reg_if #(.BIT_WIDTH(1))  if1  ();

    ripple_carry_adder_reg #(.BIT_WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
    ripple_carry_adder_reg #(.BIT_WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    ripple_carry_adder_reg #(.BIT_WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one stimulus to all three widths (narrower ones take the low bits).
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic ci);
        if32.in_valid = v; if32.in0 = a;      if32.in1 = b;      if32.carry_in = ci;
        if8.in_valid  = v; if8.in0  = a[7:0]; if8.in1  = b[7:0]; if8.carry_in  = ci;
        if1.in_valid  = v; if1.in0  = a[0];   if1.in1  = b[0];   if1.carry_in  = ci;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({if32.carry_out, if32.out, if32.out_valid} !== 34'd0) begin
            errors++;
            $display("FAIL reset_hold32: got co=%b out=%h vld=%b, want 0 0 0", if32.carry_out, if32.out, if32.out_valid);
        end
        checks++;
        if ({if8.carry_out, if8.out, if8.out_valid, if1.carry_out, if1.out, if1.out_valid} !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold_narrow: got out8=%h vld8=%b out1=%b vld1=%b, want all 0", if8.out, if8.out_valid, if1.out, if1.out_valid);
        end
`ifdef RCA_OVERFLOW_EN
        checks++;
        if (if32.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", if32.overflow);
        end
`endif
        // First edge after release samples normally.
        rst_n = 1'b1;
        drive(1'b1, 32'd5, 32'd7, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (if32.out !== 32'd12 || if32.carry_out !== 1'b0 || if32.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge: got out=%0d co=%b vld=%b, want 12 0 1", if32.out, if32.carry_out, if32.out_valid);
        end
        // Mid-stream reset clears without a clock edge.
        drive(1'b1, 32'd100, 32'd200, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (if32.out !== 32'd301 || if32.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_async_reset: got out=%0d vld=%b, want 301 1", if32.out, if32.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({if32.carry_out, if32.out, if32.out_valid} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset: got co=%b out=%h vld=%b, want 0 0 0", if32.carry_out, if32.out, if32.out_valid);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_low_sweep();
        int sweep_err;
        sweep_err = 0;
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, 32'd0, i[31:0], 1'b0);
            @(posedge clk); #1;
            checks++;
            if (if32.out !== i[31:0] || if32.carry_out !== 1'b0 || if32.out_valid !== 1'b1) begin
                errors++;
                sweep_err++;
                if (sweep_err <= 10)
                    $display("FAIL low_sweep[%0d]: got out=%h co=%b vld=%b, want %h 0 1", i, if32.out, if32.carry_out, if32.out_valid, i[31:0]);
            end
        end
        $display("low sweep: %0d vectors, %0d bad", 65536, sweep_err);
    endtask

    task automatic test_carry_extremes();
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({if32.carry_out, if32.out} !== 33'h1_0000_0000 || if32.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ones_plus1: got co=%b out=%h, want 1 00000000", if32.carry_out, if32.out);
        end
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        checks++;
        if ({if32.carry_out, if32.out} !== 33'h1_FFFF_FFFF) begin
            errors++;
            $display("FAIL max_plus_max_ci: got co=%b out=%h, want 1 ffffffff", if32.carry_out, if32.out);
        end
        checks++;
        if ({if8.carry_out, if8.out} !== 9'h1FF || {if1.carry_out, if1.out} !== 2'b11) begin
            errors++;
            $display("FAIL max_narrow: got w8=%b_%h w1=%b_%b, want 1_ff 1_1", if8.carry_out, if8.out, if1.carry_out, if1.out);
        end
        drive(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
        @(posedge clk); #1;
        checks++;
        if ({if32.carry_out, if32.out} !== 33'h1_0000_0000) begin
            errors++;
            $display("FAIL ones_plus_ci: got co=%b out=%h, want 1 00000000", if32.carry_out, if32.out);
        end
    endtask

    task automatic test_full_ripple();
        drive(1'b1, 32'h7FFF_FFFF, 32'h0, 1'b1);
        @(posedge clk); #1;
        checks++;
        if ({if32.carry_out, if32.out} !== 33'h0_8000_0000) begin
            errors++;
            $display("FAIL full_ripple: got co=%b out=%h, want 0 80000000", if32.carry_out, if32.out);
        end
        // Narrow widths see 0xFF+0+1 and 1+0+1.
        checks++;
        if ({if8.carry_out, if8.out} !== 9'h100 || {if1.carry_out, if1.out} !== 2'b10) begin
            errors++;
            $display("FAIL full_ripple_narrow: got w8=%b_%h w1=%b_%b, want 1_00 1_0", if8.carry_out, if8.out, if1.carry_out, if1.out);
        end
`ifdef RCA_OVERFLOW_EN
        checks++;
        if (if32.overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_ripple_ovf: got %b want 1", if32.overflow);
        end
`endif
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'd5, 32'd3, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (if32.out !== 32'd8 || if32.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got out=%0d vld=%b, want 8 1", if32.out, if32.out_valid);
        end
        drive(1'b1, 32'd10, 32'd20, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (if32.out !== 32'd30 || if32.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got out=%0d vld=%b, want 30 1", if32.out, if32.out_valid);
        end
        drive(1'b0, 32'd99, 32'd20, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (if32.out !== 32'd30 || if32.carry_out !== 1'b0 || if32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_invalid: got out=%0d co=%b vld=%b, want 30 0 0", if32.out, if32.carry_out, if32.out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        ci, v;
        logic [32:0] exp32;
        logic [8:0]  exp8;
        logic [1:0]  exp1;
        logic        ov32, ov8;
        int          rnd_err;
        rnd_err = 0;
        drive(1'b1, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        exp32 = '0; exp8 = '0; exp1 = '0; ov32 = 1'b0; ov8 = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            a  = $urandom;
            b  = $urandom;
            ci = 1'($urandom_range(0, 1));
            v  = 1'($urandom_range(0, 1));
            drive(v, a, b, ci);
            @(posedge clk); #1;
            if (v) begin
                exp32 = {1'b0, a} + {1'b0, b} + {32'd0, ci};
                exp8  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, ci};
                exp1  = {1'b0, a[0]} + {1'b0, b[0]} + {1'b0, ci};
                ov32  = (a[31] == b[31]) && (exp32[31] != a[31]);
                ov8   = (a[7] == b[7]) && (exp8[7] != a[7]);
            end
            checks++;
            if ({if32.carry_out, if32.out} !== exp32 || {if8.carry_out, if8.out} !== exp8 ||
                {if1.carry_out, if1.out} !== exp1 ||
                {if32.out_valid, if8.out_valid, if1.out_valid} !== {3{v}}) begin
                errors++;
                rnd_err++;
                if (rnd_err <= 10)
                    $display("FAIL random[%0d]: got w32=%h w8=%h w1=%b vld=%b%b%b, want %h %h %b vld=%b", n,
                             {if32.carry_out, if32.out}, {if8.carry_out, if8.out}, {if1.carry_out, if1.out},
                             if32.out_valid, if8.out_valid, if1.out_valid, exp32, exp8, exp1, v);
            end
`ifdef RCA_OVERFLOW_EN
            checks++;
            if (if32.overflow !== ov32 || if8.overflow !== ov8) begin
                errors++;
                rnd_err++;
                if (rnd_err <= 10)
                    $display("FAIL random_ovf[%0d]: got %b %b want %b %b", n, if32.overflow, if8.overflow, ov32, ov8);
            end
`endif
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        test_reset();
        test_low_sweep();
        test_carry_extremes();
        test_full_ripple();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ripple_carry_adder_reg.md
Name: ripple_carry_adder_reg

Overview:
Parameterised BIT_WIDTH ripple-carry adder, built as a chain of 1-bit full adders, with a registered output stage.
- Computes {carry_out, out} = in0 + in1 + carry_in.
- Sits in the arithmetic datapath, e.g. as the final carry-propagate stage after a carry-save tree.
- Single clock; a valid flag travels alongside the data.

Parameters:
- BIT_WIDTH, 32: operand and sum width in bits; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies in0/in1/carry_in in the current cycle.
- in0  input  BIT_WIDTH  operand A, unsigned.
- in1  input  BIT_WIDTH  operand B, unsigned.
- carry_in  input  1  carry into bit 0.
- out  output  BIT_WIDTH  registered sum, bits [BIT_WIDTH-1:0].
- carry_out  output  1  registered carry out of bit BIT_WIDTH-1.
- out_valid  output  1  out/carry_out hold a result for the sample taken one cycle earlier.

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Datapath:
  - Combinational ripple chain of BIT_WIDTH full adders, instantiated with a generate loop.
  - c[0] = carry_in; s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - No carry lookahead, no carry skip.
- Arithmetic: exact unsigned sum, BIT_WIDTH+1 bits wide.
  - {carry_out, out} == in0 + in1 + carry_in, with no truncation.
  - Wrap-around: all-ones + 1 gives out = 0, carry_out = 1.
- Latency: exactly 1 cycle. The inputs present at rising edge N appear on out/carry_out after edge N.
- Valid rules:
  - out_valid <= in_valid on every edge.
  - The data registers load on every edge where in_valid = 1.
  - When in_valid = 0, the data registers hold their previous value and out_valid drops to 0.
  - Throughput is one result per cycle. There is no backpressure and no stall input.
- Reset:
  - While rst_n = 0, out = 0, carry_out = 0, out_valid = 0, immediately and without waiting for a clock.
  - Reset mid-stream discards the in-flight result.
  - The first edge after rst_n deasserts samples the inputs normally.
- Combinational path: the inputs reach the registers through the full ripple chain. Timing closure at BIT_WIDTH = 32 is the integrator's responsibility.
- Undefined inputs: X on any input bit propagates. No X-suppression logic.

Optional Feature:
- Macro: RCA_OVERFLOW_EN.
- When defined:
  - Adds output port overflow (1 bit, registered with the same timing, valid handling and reset value 0 as out).
  - overflow = c[BIT_WIDTH] ^ c[BIT_WIDTH-1], i.e. two's-complement signed overflow of in0 + in1 + carry_in.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: rst_n = 0 with arbitrary inputs and clk running -> out = 0, carry_out = 0, out_valid = 0. Asserting rst_n mid-stream clears the outputs immediately, with no clock edge.
- Exhaustive low sweep:
  - Stimulus: BIT_WIDTH = 32, in0 = 0, carry_in = 0, in1 = 0x0000..0xFFFF, in_valid = 1.
  - Check each cycle: {carry_out, out} == in0 + in1 from the previous cycle (out = in1, carry_out = 0).
  - Finish with a single pass/fail summary.
- Carry extremes:
  - in0 = 0xFFFFFFFF, in1 = 0x00000001, carry_in = 0 -> out = 0x00000000, carry_out = 1.
  - in0 = in1 = 0xFFFFFFFF, carry_in = 1 -> out = 0xFFFFFFFF, carry_out = 1.
  - in0 = 0xFFFFFFFF, in1 = 0, carry_in = 1 -> out = 0, carry_out = 1.
- Full ripple: in0 = 0x7FFFFFFF, in1 = 0, carry_in = 1 -> out = 0x80000000, carry_out = 0. With RCA_OVERFLOW_EN, overflow = 1.
- Valid and hold:
  - Back-to-back in_valid = 1 with values 5+3 then 10+20 -> out = 8 then 30, out_valid = 1 on both cycles.
  - Then in_valid = 0 with in0 = 99 -> out holds 30, out_valid = 0.
- Random regression: 10,000 random in0/in1/carry_in with random in_valid -> every valid output matches the (BIT_WIDTH+1)-bit reference sum. Repeat with BIT_WIDTH = 1 and BIT_WIDTH = 8.
